// File: rtl/mem_arbiter_if.sv
// Bus between two memory requesters, the arbiter and a single-port memory.
// Handshake: a requester raises reqN with wrN/addrN/wdataN and holds it until
// doneN pulses for one cycle; rdata is valid only in that cycle.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              grant_id;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done0, done1, rdata, busy, grant_id, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, rdata, busy, grant_id, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters fixed-latency access to one
// single-port memory through an IDLE -> BUSY -> DONE sequence.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  mem_arbiter_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_grant;
  logic       accept;
  logic       win;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    // With both requesting, the one not served last wins; a lone requester always wins.
    win       = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt           <= 4'd0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rdata     <= '0;
      bus.grant_id  <= 1'b0;
      last_grant    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.grant_id  <= win;
            bus.mem_wr    <= win ? bus.wr1    : bus.wr0;
            bus.mem_addr  <= win ? bus.addr1  : bus.addr0;
            bus.mem_wdata <= win ? bus.wdata1 : bus.wdata0;
            cnt           <= 4'(MEM_LAT);
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Writes leave the last read data in place.
            if (!bus.mem_wr) bus.rdata <= bus.mem_rdata;
            bus.mem_wr <= 1'b0;
          end
        end
        DONE: last_grant <= bus.grant_id;
        default: ;
      endcase
    end
  end

  assign bus.done0 = (state == DONE) && !bus.grant_id;
  assign bus.done1 = (state == DONE) &&  bus.grant_id;
  assign bus.busy  = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: driver tasks push expected completions into
// a queue and a negedge monitor pops and compares them on every done pulse.
module tb_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
  localparam int W       = 16 + 1 + DATA_W;

  logic        Clk;
  logic        Reset;
  logic [1:0]  state_dbg;
  logic [15:0] cyc;
  int          errors;
  int          checks;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Memory model: 0x10 holds DEADBEEF, every other address reads addr ^ CAFE0000.
  assign bus.mem_rdata = (bus.mem_addr == 32'h10) ? 32'hDEADBEEF : (bus.mem_addr ^ 32'hCAFE0000);

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  initial cyc = 16'd0;
  always @(posedge Clk) cyc <= cyc + 16'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (bus.done0 || bus.done1) begin
      chk("done_excl", 64'(bus.done0 & bus.done1), 64'd0);
      if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("done", 64'({cyc, bus.done1, bus.rdata}), 64'(mon_e));
      end
    end
  end

  // Driver tasks
  task automatic set_req(input bit id, input bit on, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      bus.req1 = on; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = on; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic expect_done(input logic [15:0] at, input bit id, input logic [31:0] rd);
    exp_q.push_back({at, id, rd});
  endtask

  task automatic access(input bit id, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    set_req(id, 1'b1, wr, a, d);
    expect_done(cyc + 16'(MEM_LAT + 1), id, exp_rd);
    for (int n = 1; n <= MEM_LAT; n++) begin
      @(negedge Clk);
      chk("busy_access", 64'(bus.busy), 64'd1);
      chk("grant_id", 64'(bus.grant_id), 64'(id));
      chk("mem_wr_busy", 64'(bus.mem_wr), 64'(wr));
      chk("mem_addr", 64'(bus.mem_addr), 64'(a));
      if (wr) chk("mem_wdata", 64'(bus.mem_wdata), 64'(d));
    end
    @(negedge Clk);
    chk("busy_done", 64'(bus.busy), 64'd1);
    chk("mem_wr_done", 64'(bus.mem_wr), 64'd0);
    set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    chk("busy_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [15:0] c;
    errors = 0;
    checks = 0;
    Reset  = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge Clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'({bus.done0, bus.done1}), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Single read, then single write that must leave rdata alone
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'h40, 32'h12345678, 32'hDEADBEEF);

    // Simultaneous held requests straight from reset: grants 0,1,0,1
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    c = cyc;
    set_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    expect_done(c + 16'd3,  1'b0, 32'hCAFE0020);
    expect_done(c + 16'd7,  1'b1, 32'hCAFE0030);
    expect_done(c + 16'd11, 1'b0, 32'hCAFE0020);
    expect_done(c + 16'd15, 1'b1, 32'hCAFE0030);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge Clk);
        if (k == 0) chk("rr_grant", 64'(bus.grant_id), 64'(g % 2));
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    chk("rr_idle", 64'(bus.busy), 64'd0);

    // Request dropped after one cycle still completes, then no further grant
    c = cyc;
    set_req(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    expect_done(c + 16'd3, 1'b0, 32'hCAFE0050);
    @(negedge Clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge Clk);
    chk("drop_busy", 64'(bus.busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("drop_idle", 64'({bus.busy, state_dbg}), 64'd0);
    end

    // Reset in cycle 2 of a write aborts it; last_grant returns to 1
    set_req(1'b1, 1'b1, 1'b1, 32'h44, 32'hAAAA5555);
    @(negedge Clk);
    chk("abort_wr1", 64'(bus.mem_wr), 64'd1);
    @(negedge Clk);
    chk("abort_wr2", 64'(bus.mem_wr), 64'd1);
    Reset = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    repeat (2) begin
      @(negedge Clk);
      chk("abort_idle", 64'(bus.busy), 64'd0);
    end
    c = cyc;
    set_req(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h70, 32'h0);
    expect_done(c + 16'd3, 1'b0, 32'hCAFE0060);
    expect_done(c + 16'd7, 1'b1, 32'hCAFE0070);
    @(negedge Clk);
    chk("abort_grant", 64'(bus.grant_id), 64'd0);
    repeat (2) @(negedge Clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge Clk);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);

    // Address change during BUSY must not reach mem_addr
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    expect_done(cyc + 16'd3, 1'b0, 32'hDEADBEEF);
    @(negedge Clk);
    chk("stable_addr1", 64'(bus.mem_addr), 64'h10);
    bus.addr0 = 32'h99;
    @(negedge Clk);
    chk("stable_addr2", 64'(bus.mem_addr), 64'h10);
    @(negedge Clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (3) @(negedge Clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 2, range 1..15, meaning memory cycles per access.
REQ-004 The block SHALL have port Clk, input, 1, meaning the single clock; every register updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1, meaning synchronous active-high reset, sampled on the rising edge of Clk.
REQ-006 The block SHALL have ports req0 and req1, input, 1 each, meaning an access request from requester 0 (CPU control unit) or requester 1 (loader/DMA).
REQ-007 The block SHALL have ports wr0 and wr1, input, 1 each, meaning 1 = write and 0 = read.
REQ-008 The block SHALL have ports addr0 and addr1, input, ADDR_W each, meaning the access address.
REQ-009 The block SHALL have ports wdata0 and wdata1, input, DATA_W each, meaning the write data.
REQ-010 The block SHALL have ports done0 and done1, output, 1 each, meaning a one-cycle completion pulse to requester 0 or requester 1.
REQ-011 The block SHALL have port rdata, output, DATA_W, meaning read data, shared by both requesters and valid while doneN=1.
REQ-012 The block SHALL have port busy, output, 1, meaning an access is in progress (state BUSY or DONE).
REQ-013 The block SHALL have port grant_id, output, 1, meaning the requester currently owning the memory.
REQ-014 The block SHALL have ports mem_addr (ADDR_W), mem_wr (1) and mem_wdata (DATA_W), all outputs, meaning the registered drive to the single-port memory.
REQ-015 The block SHALL have port mem_rdata, input, DATA_W, meaning read data returned by the memory.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-017 In IDLE, if req0 or req1 is 1 at a rising edge, the block SHALL select a winner, latch that requester's wrN, addrN and wdataN into mem_wr, mem_addr and mem_wdata, set grant_id to the winner, load cnt=MEM_LAT, and go to BUSY.
REQ-018 Arbitration SHALL be round-robin: a lone requester always wins; when both request, the winner is the requester not served last (register last_grant).
REQ-019 In BUSY, cnt SHALL decrement once per cycle; on the edge where cnt==1 the block SHALL capture mem_rdata into rdata, drive mem_wr=0, and go to DONE.
REQ-020 In DONE, done[grant_id] SHALL be 1 for exactly one cycle; last_grant SHALL take the value of grant_id, and the next state SHALL be IDLE unconditionally.
REQ-021 Latency SHALL be fixed: a request accepted at edge k SHALL produce its doneN pulse in cycle k+MEM_LAT+1, and the memory SHALL stay idle for one cycle before the next acceptance.
REQ-022 For writes, mem_wr SHALL be held at 1 during all BUSY cycles and be 0 at all other times; rdata SHALL be unchanged by write accesses.
REQ-023 mem_addr and mem_wdata SHALL be stable throughout BUSY, independent of later changes on addrN and wdataN.
REQ-024 If reqN is deasserted during BUSY, the access SHALL still complete and doneN SHALL still pulse; an aborted request is not supported.
REQ-025 A requester SHALL hold reqN until it sees doneN; a request still asserted in the IDLE cycle after DONE SHALL be treated as a new access.
REQ-026 The block SHALL never assert done0 and done1 in the same cycle.
REQ-027 The block SHALL never accept a request while in BUSY or DONE.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and set cnt=0, done0=done1=0, busy=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, grant_id=0, last_grant=1, so that requester 0 wins the first simultaneous request.
REQ-029 Reset asserted mid-access SHALL abort the access at that edge, with no doneN pulse and mem_wr=0 from the next cycle.

Verification (MEM_LAT=2)
REQ-030 The bench SHALL check a single read: req0=1, wr0=0, addr0=0x10, memory returns 0xDEADBEEF, accepted at edge 0 -> done0=1 and rdata=0xDEADBEEF in cycle 3; busy=1 in cycles 1-3; done1 never asserts.
REQ-031 The bench SHALL check a single write: req1=1, wr1=1, addr1=0x40, wdata1=0x12345678 -> mem_wr=1 with mem_addr=0x40 and mem_wdata=0x12345678 in cycles 1-2; done1=1 in cycle 3; rdata unchanged.
REQ-032 The bench SHALL check simultaneous requests from reset: req0=req1=1 held -> grant order 0,1,0,1, with done pulses in cycles 3, 7, 11, 15.
REQ-033 The bench SHALL check request drop: req0 pulsed for one cycle only -> access completes and done0=1 in cycle 3, then the block returns to IDLE with no further grant.
REQ-034 The bench SHALL check reset mid-access: Reset=1 in cycle 2 of a write -> mem_wr=0, busy=0 and no doneN pulse afterward; a subsequent simultaneous request is granted to requester 0.
REQ-035 The bench SHALL check address stability: addr0 changes during BUSY -> mem_addr keeps the value latched at acceptance.
